// File: rtl/prio_irq_ctrl.sv
// Priority interrupt controller. It captures falling edges on N active-low
// request lines into a pending register. The highest unmasked pending
// channel is presented to the CPU through an irq/ack/eoi handshake, and
// encoder-style group-select / enable-out outputs allow cascading.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_req_n      [N] request lines, active-low, edge-captured
//   i_mask       [N] 1 = channel excluded from selection (still latched)
//   i_enable_n   global enable, active-low
//   i_ack        CPU acknowledge pulse (honoured in PEND only)
//   i_eoi        end-of-interrupt pulse (honoured in INSVC only)
//   o_irq        registered interrupt request
//   o_vec        [W] registered channel number requested / in service
//   o_insvc      registered in-service flag
//   o_gs_n       comb: low when enabled and any unmasked pending bit
//   o_enable_n   comb: low when enabled and no unmasked pending bit
module prio_irq_ctrl #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req_n,
  input  logic [N-1:0] i_mask,
  input  logic         i_enable_n,
  input  logic         i_ack,
  input  logic         i_eoi,
  output logic         o_irq,
  output logic [W-1:0] o_vec,
  output logic         o_insvc,
  output logic         o_gs_n,
  output logic         o_enable_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    INSVC = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [N-1:0]   req_prev;
  logic [N-1:0]   pending, pending_nx;
  logic [N-1:0]   sel;
  logic [N-1:0]   set_vec, clr_vec;
  logic [W-1:0]   winner;
  logic           any_sel;
  logic           take_ack;
  logic           irq_nx, insvc_nx;
  logic [W-1:0]   vec_nx;

  assign sel     = pending & ~i_mask;
  assign any_sel = |sel;
  assign set_vec = ~i_req_n & req_prev;

  // Highest set index of sel; later iterations override earlier ones.
  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel[i]) winner = W'(i);
    end
  end

  // Pending update: a new falling edge wins over a clear in the same cycle.
  always_comb begin
    clr_vec = '0;
    if (take_ack) clr_vec[o_vec] = 1'b1;
    pending_nx = (pending & ~clr_vec) | set_vec;
  end

  // Encoder-style cascade outputs, purely from pending/mask/enable.
  assign o_gs_n     = i_enable_n | ~any_sel;
  assign o_enable_n = i_enable_n | any_sel;

  assign take_ack = (state == PEND) && i_ack;

  // Next-state and registered-output values.
  always_comb begin
    state_nx = state;
    irq_nx   = 1'b0;
    insvc_nx = 1'b0;
    vec_nx   = o_vec;
    unique case (state)
      IDLE: begin
        if (!i_enable_n && any_sel) begin
          state_nx = PEND;
          irq_nx   = 1'b1;
          vec_nx   = winner;
        end
      end
      PEND: begin
        if (i_ack) begin
          state_nx = INSVC;
          insvc_nx = 1'b1;
        end else if (i_enable_n || !sel[o_vec]) begin
          state_nx = IDLE;
        end else begin
          irq_nx = 1'b1;
        end
      end
      INSVC: begin
        if (i_eoi) begin
          state_nx = IDLE;
        end else begin
          insvc_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      req_prev <= '1;
      pending  <= '0;
      o_irq    <= 1'b0;
      o_vec    <= '0;
      o_insvc  <= 1'b0;
    end else begin
      state    <= state_nx;
      req_prev <= i_req_n;
      pending  <= pending_nx;
      o_irq    <= irq_nx;
      o_vec    <= vec_nx;
      o_insvc  <= insvc_nx;
    end
  end

endmodule

// File: doc/prio_irq_ctrl.md
# prio_irq_ctrl

Parametrised, clocked priority interrupt controller: the sequential successor to the 8-to-3 active-low priority encoder. It captures N active-low request lines into a pending register and applies a per-channel mask. It then presents the highest-priority unmasked channel as a registered vector with an irq/ack/eoi handshake. It keeps encoder-style group-select and enable-out outputs so controllers can be cascaded, and sits between peripheral request lines and the CPU interrupt input.

## Interface
- N, default 8, number of request channels (N ≥ 2); channel N-1 is highest priority.
- W, default $clog2(N), vector width.

- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_n  in  N  request lines, active-low, synchronous to i_clk.
- i_mask  in  N  1 = channel masked (excluded from selection, still latched).
- i_enable_n  in  1  global enable, active-low.
- i_ack  in  1  CPU acknowledge, 1-cycle pulse.
- i_eoi  in  1  end-of-interrupt, 1-cycle pulse.
- o_irq  out  1  interrupt request to CPU.
- o_vec  out  W  registered channel number being requested/serviced.
- o_insvc  out  1  a channel is in service.
- o_gs_n  out  1  low when enabled and any unmasked pending bit.
- o_enable_n  out  1  low when enabled and no unmasked pending bit (cascade enable to lower-priority stage).

## Operation
- Capture: register req_prev (N bits) holds last-cycle i_req_n. pending[i] is set at an edge where i_req_n[i]==0 and req_prev[i]==1 (falling edge). Held-low levels do not re-set pending.
- Mask gates selection only. pending is set regardless of i_mask and i_enable_n.
- sel = pending & ~i_mask. The winner is the highest set index of sel.
- FSM, three states:
  - IDLE: if i_enable_n==0 and sel≠0, latch o_vec = winner and go to PEND.
  - PEND: o_irq=1 and o_vec frozen; a higher-priority arrival does not change o_vec.
    - If i_ack, clear pending[o_vec] and go to INSVC.
    - Else if i_enable_n==1 or sel[o_vec]==0 (masked), withdraw: go to IDLE with o_irq=0 and pending unchanged.
  - INSVC: o_irq=0, o_insvc=1, o_vec held. On i_eoi, go to IDLE.
- Acks outside PEND and eois outside INSVC are ignored.
- Simultaneous set and clear on the same channel (new falling edge in the ack cycle): set wins and pending stays 1.
- o_gs_n and o_enable_n are combinational from the pending register, i_mask and i_enable_n. There is no path from i_req_n.
  - If i_enable_n==1, both are 1.
- Reset values: pending=0, req_prev=all-ones, state IDLE, o_irq=0, o_vec=0, o_insvc=0.
  - A request held low through reset is therefore captured on the first edge after release.
- Reset mid-handshake aborts everything. There is no memory of in-service or pending channels.

## Timing
- Falling request sampled at edge t: pending visible after t, o_irq=1 and o_vec valid after edge t+1. Latency is 2 edges.
- i_ack sampled at edge a in PEND: after a, o_irq=0, o_insvc=1 and pending[o_vec]=0.
- i_eoi sampled at edge e: after e, o_insvc=0. The next o_irq can rise after edge e+1 at the earliest.
- Withdraw (mask or disable in PEND) drops o_irq after the same edge that samples the condition.
- o_vec changes only on the IDLE→PEND transition and on reset.

## Test plan
- N=8, reset then i_req_n=8'b11111110 at edge t: pending=0x01 after t; o_irq=1, o_vec=0 after t+1. i_ack: o_insvc=1, pending=0. i_eoi: back to IDLE, o_irq stays 0.
- i_req_n 8'hFF→8'h00 at one edge: o_vec=7. Ack/eoi repeated: vectors 7,6,5,…,0 in order, each a separate handshake; o_enable_n=0 after last eoi.
- i_mask=8'h80 with channels 7 and 3 pending: o_vec=3, o_gs_n=0. Then clear mask in INSVC: after eoi, next o_vec=7.
- In PEND on ch2, drive i_enable_n=1: o_irq drops next edge, pending[2] still 1, o_gs_n=o_enable_n=1. Re-enable: o_irq returns with o_vec=2.
- New falling edge on ch4 in the same cycle as ack of ch4: pending[4] remains 1, and ch4 is re-requested after eoi.
- Assert i_rst asynchronously while in INSVC with pending=0x30: all outputs reset immediately without a clock edge. Requests held low through reset are re-captured on the first edge after release.
